// File: rtl/dbg_arb_pkg.sv
// Shared types and helpers for the debug/core memory arbiter.
// State encoding, constant data patterns and counter sizing.
package dbg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_ACC = 2'd1,
        DBG_ACC  = 2'd2
    } arb_state_t;

    localparam logic [127:0] ALL_ONES = '1;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dbg_mem_arbiter_capture.sv
// Debug request capture: edge detect on the debug enables feeding a
// single-entry pending slot, with overflow and collision flagging.
module dbg_req_capture
    import dbg_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          read_enable,
    input  logic          write_enable,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] write_data,
    input  logic          clear,
    output logic          valid,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    output logic          err
);

    logic rd_q;
    logic wr_q;
    logic rd_edge;
    logic wr_edge;
    logic any_edge;

    always_comb begin
        rd_edge  = read_enable & ~rd_q;
        wr_edge  = write_enable & ~wr_q;
        any_edge = rd_edge | wr_edge;
        err      = (any_edge & valid) | (rd_edge & wr_edge);
    end

    // a write wins a same-cycle collision; edges into a busy slot are lost
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            valid <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            rd_q <= read_enable;
            wr_q <= write_enable;
            if (clear) begin
                valid <= 1'b0;
            end else if (any_edge && !valid) begin
                valid <= 1'b1;
                we    <= wr_edge;
                addr  <= address;
                wdata <= write_data;
            end
        end
    end

endmodule

// File: rtl/dbg_mem_arbiter.sv
// Shares one memory bus between the core load/store port and the debug
// module, with debug priority, core starvation guard and bus timeout.
module dbg_mem_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MAX_DBG_BURST  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          halt,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_read_enable,
    input  logic          dbg_write_enable,
    input  logic [AW-1:0] dbg_address,
    input  logic [DW-1:0] dbg_write_data,
    output logic [DW-1:0] dbg_read_data,
    output logic          dbg_done,
    output logic          dbg_busy,
    output logic          dbg_err,
    input  logic          err_clr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int SW = cnt_width(MAX_DBG_BURST);
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] S_MAX = SW'(MAX_DBG_BURST);
    localparam logic [TW-1:0] T_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] to_cnt;

    logic          slot_valid;
    logic          slot_we;
    logic [AW-1:0] slot_addr;
    logic [DW-1:0] slot_wdata;
    logic          cap_err;

    logic          in_acc;
    logic          timeout_hit;
    logic          finish;
    logic          blocked;
    logic          dbg_go;
    logic          core_go;
    logic          grant_dbg;
    logic          grant_core;
    logic          dbg_clear;
    logic [DW-1:0] rdata_sel;

    dbg_req_capture #(
        .AW(AW),
        .DW(DW)
    ) u_capture (
        .clk         (clk),
        .reset       (reset),
        .read_enable (dbg_read_enable),
        .write_enable(dbg_write_enable),
        .address     (dbg_address),
        .write_data  (dbg_write_data),
        .clear       (dbg_clear),
        .valid       (slot_valid),
        .we          (slot_we),
        .addr        (slot_addr),
        .wdata       (slot_wdata),
        .err         (cap_err)
    );

    assign dbg_busy = slot_valid;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_dbg)       state_nxt = DBG_ACC;
                else if (grant_core) state_nxt = CORE_ACC;
            end
            CORE_ACC, DBG_ACC: begin
                if (finish) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // the completion cycle is never a grant cycle, so a core still
    // holding core_req while seeing its ack is not served twice
    always_comb begin
        in_acc      = (state != IDLE);
        timeout_hit = in_acc && !mem_ready && (TIMEOUT_CYCLES != 0)
                      && (to_cnt == T_LAST);
        finish      = in_acc && (mem_ready || timeout_hit);
        blocked     = core_ack || dbg_done;
        dbg_go      = slot_valid
                      && (halt || !core_req || (starve_cnt < S_MAX));
        core_go     = core_req && !halt;
        grant_dbg   = (state == IDLE) && !blocked && dbg_go;
        grant_core  = (state == IDLE) && !blocked && !dbg_go && core_go;
        dbg_clear   = finish && (state == DBG_ACC);
        rdata_sel   = mem_ready ? mem_rdata : ALL_ONES[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            if (!core_req || grant_core)
                starve_cnt <= '0;
            else if (grant_dbg && (starve_cnt < S_MAX))
                starve_cnt <= starve_cnt + 1'b1;
            if (!in_acc || finish) to_cnt <= '0;
            else                   to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            core_ack      <= 1'b0;
            core_rdata    <= '0;
            dbg_done      <= 1'b0;
            dbg_read_data <= '0;
        end else begin
            core_ack <= 1'b0;
            dbg_done <= 1'b0;
            if (grant_dbg) begin
                mem_req   <= 1'b1;
                mem_we    <= slot_we;
                mem_addr  <= slot_addr;
                mem_wdata <= slot_wdata;
            end else if (grant_core) begin
                mem_req   <= 1'b1;
                mem_we    <= core_we;
                mem_addr  <= core_addr;
                mem_wdata <= core_wdata;
            end else if (finish) begin
                mem_req <= 1'b0;
                if (state == CORE_ACC) begin
                    core_ack <= 1'b1;
                    if (!mem_we) core_rdata <= rdata_sel;
                end else begin
                    dbg_done <= 1'b1;
                    if (!mem_we) dbg_read_data <= rdata_sel;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                       dbg_err <= 1'b0;
        else if (cap_err || timeout_hit) dbg_err <= 1'b1;
        else if (err_clr)                dbg_err <= 1'b0;
    end

endmodule
